// File: rtl/slave_cmd_spi_pkg.sv
// slave_cmd_spi_pkg: shared transaction states and fixed byte values for the
// command-to-SPI bridge.
package slave_cmd_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        CMD_BYTE,
        RESP_BYTE,
        CS_HOLD,
        CS_INACTIVE
    } state_t;

    localparam logic [4:0] CMD_PREFIX = 5'b00000;
    localparam logic [7:0] DUMMY_BYTE = 8'h00;

    function automatic logic [7:0] cmd_byte(input logic [2:0] cmd);
        return {CMD_PREFIX, cmd};
    endfunction

endpackage

// File: rtl/spi_master_byte.sv
// spi_master_byte: shifts one byte out on MOSI and one byte in from MISO,
// generating the SPI clock for the selected mode.
module spi_master_byte #(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    input  logic       i_miso,
    output logic       o_done,
    output logic [7:0] o_byte,
    output logic       o_sclk,
    output logic       o_mosi
);

    localparam logic CPOL = (SPI_MODE & 2) != 0;
    localparam logic CPHA = (SPI_MODE & 1) != 0;
    localparam int   CW   = CLKS_PER_HALF_BIT > 1 ? $clog2(CLKS_PER_HALF_BIT) : 1;

    logic [CW-1:0] r_cnt;
    logic [3:0]    r_edges;
    logic          r_busy;
    logic          r_sclk;
    logic          r_mosi;
    logic [7:0]    r_tx;
    logic [7:0]    r_rx;
    logic          w_edge;
    logic          w_shift;

    // Even edge numbers are leading edges; CPHA picks which kind shifts MOSI.
    assign w_edge  = r_busy && r_cnt == CW'(CLKS_PER_HALF_BIT - 1);
    assign w_shift = r_edges[0] ^ CPHA;
    assign o_done  = w_edge && r_edges == 4'd15;
    assign o_byte  = r_rx;
    assign o_sclk  = r_sclk;
    assign o_mosi  = r_mosi;

    // A start on the final edge reloads without a gap, keeping bit timing continuous.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_edges <= '0;
            r_sclk  <= CPOL;
            r_mosi  <= 1'b0;
            r_tx    <= '0;
            r_rx    <= '0;
        end else begin
            r_cnt <= w_edge ? '0 : (r_busy ? r_cnt + 1'b1 : r_cnt);
            if (w_edge) begin
                r_sclk  <= ~r_sclk;
                r_edges <= r_edges + 1'b1;
                if (w_shift) begin
                    r_mosi <= r_tx[7];
                    r_tx   <= {r_tx[6:0], 1'b0};
                end else begin
                    r_rx <= {r_rx[6:0], i_miso};
                end
                if (o_done) r_busy <= 1'b0;
            end
            if (i_start) begin
                r_busy  <= 1'b1;
                r_cnt   <= '0;
                r_edges <= '0;
                r_tx    <= CPHA ? i_byte : {i_byte[6:0], 1'b0};
                if (!CPHA) r_mosi <= i_byte[7];
            end
        end
    end

endmodule

// File: rtl/slave_command_to_spi.sv
// slave_command_to_spi: turns a 3-bit command strobe into a two-byte SPI
// transaction and returns the slave's response byte.
module slave_command_to_spi
    import slave_cmd_spi_pkg::*;
#(
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int SPI_MODE          = 0,
    parameter int CS_INACTIVE_CLKS  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       transmit,
    input  logic [2:0] command,
    output logic       ready,
    output logic [7:0] tx_byte,
    output logic       valid_out,
    output logic       o_SPI_Clk,
    input  logic       i_SPI_MISO,
    output logic       o_SPI_MOSI,
    output logic       o_SPI_CS_n
);

    localparam int IW = $clog2(CS_INACTIVE_CLKS + 1);

    state_t        r_state;
    state_t        w_next;
    logic [2:0]    r_cmd;
    logic [IW-1:0] r_icnt;
    logic          w_start;
    logic          w_done;
    logic          w_active;
    logic          w_mosi;
    logic [7:0]    w_tx;
    logic [7:0]    w_rx;

    spi_master_byte #(
        .SPI_MODE          (SPI_MODE),
        .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT)
    ) u_byte (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_byte  (w_tx),
        .i_miso  (i_SPI_MISO),
        .o_done  (w_done),
        .o_byte  (w_rx),
        .o_sclk  (o_SPI_Clk),
        .o_mosi  (w_mosi)
    );

    assign w_active   = r_state inside {CS_SETUP, CMD_BYTE, RESP_BYTE, CS_HOLD};
    assign w_start    = r_state == CS_SETUP || (r_state == CMD_BYTE && w_done);
    assign w_tx       = r_state == CS_SETUP ? cmd_byte(r_cmd) : DUMMY_BYTE;
    assign ready      = r_state == IDLE;
    assign o_SPI_CS_n = ~w_active;
    assign o_SPI_MOSI = w_active & w_mosi;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:        w_next = transmit ? CS_SETUP : IDLE;
            CS_SETUP:    w_next = CMD_BYTE;
            CMD_BYTE:    w_next = w_done ? RESP_BYTE : CMD_BYTE;
            RESP_BYTE:   w_next = w_done ? CS_HOLD : RESP_BYTE;
            CS_HOLD:     w_next = CS_INACTIVE;
            CS_INACTIVE: w_next = r_icnt == IW'(CS_INACTIVE_CLKS - 1) ? IDLE : CS_INACTIVE;
            default:     w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmd     <= '0;
            r_icnt    <= '0;
            tx_byte   <= '0;
            valid_out <= 1'b0;
        end else begin
            if (ready && transmit) r_cmd <= command;
            r_icnt    <= r_state == CS_INACTIVE ? r_icnt + 1'b1 : '0;
            valid_out <= r_state == CS_HOLD;
            if (r_state == CS_HOLD) tx_byte <= w_rx;
        end
    end

endmodule

// File: tb/tb_slave_command_to_spi.sv
// tb_slave_command_to_spi: directed vectors against a mode-0 instance and a
// mode-3 / 4-clk-half-bit instance, each with its own SPI slave model.
module tb_slave_command_to_spi;

    logic       clk = 1'b0;
    logic       rst;
    logic       transmit0, transmit3;
    logic [2:0] command0, command3;
    logic       ready0, ready3, valid0, valid3;
    logic [7:0] tx0, tx3;
    logic       sclk0, sclk3, mosi0, mosi3, cs0, cs3;
    logic       miso0 = 1'b0;
    logic       miso3 = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    slave_command_to_spi dut0 (
        .clk(clk), .rst(rst), .transmit(transmit0), .command(command0),
        .ready(ready0), .tx_byte(tx0), .valid_out(valid0),
        .o_SPI_Clk(sclk0), .i_SPI_MISO(miso0), .o_SPI_MOSI(mosi0), .o_SPI_CS_n(cs0)
    );

    slave_command_to_spi #(.CLKS_PER_HALF_BIT(4), .SPI_MODE(3), .CS_INACTIVE_CLKS(2)) dut3 (
        .clk(clk), .rst(rst), .transmit(transmit3), .command(command3),
        .ready(ready3), .tx_byte(tx3), .valid_out(valid3),
        .o_SPI_Clk(sclk3), .i_SPI_MISO(miso3), .o_SPI_MOSI(mosi3), .o_SPI_CS_n(cs3)
    );

    // Slave models: {junk FF, response} shifted out MSB first on falling SCLK.
    logic [7:0]  resp_q0[$], resp_q3[$], vq0[$], vq3[$];
    logic [15:0] mq0[$];
    logic [15:0] s_sr0, s_sr3, cap0, cap3;
    int          nrise0, nrise3, ncs0, hi0, gap0;
    time         t_first3, t_last3;

    always @(negedge cs0) begin
        s_sr0  = {8'hFF, resp_q0.size() > 0 ? resp_q0.pop_front() : 8'h00};
        miso0  = s_sr0[15];
        s_sr0  = s_sr0 << 1;
        cap0   = '0;
        nrise0 = 0;
        ncs0++;
        gap0   = hi0;
    end
    always @(negedge sclk0) if (!cs0) begin
        miso0 = s_sr0[15];
        s_sr0 = s_sr0 << 1;
    end
    always @(posedge sclk0) if (!cs0) begin
        cap0 = {cap0[14:0], mosi0};
        nrise0++;
    end
    always @(posedge cs0) mq0.push_back(cap0);
    always @(negedge clk) begin
        hi0 = cs0 ? hi0 + 1 : 0;
        if (valid0) vq0.push_back(tx0);
        if (valid3) vq3.push_back(tx3);
    end

    always @(negedge cs3) begin
        s_sr3  = {8'hFF, resp_q3.size() > 0 ? resp_q3.pop_front() : 8'h00};
        cap3   = '0;
        nrise3 = 0;
    end
    always @(negedge sclk3) if (!cs3) begin
        miso3 = s_sr3[15];
        s_sr3 = s_sr3 << 1;
    end
    always @(posedge sclk3) if (!cs3) begin
        cap3 = {cap3[14:0], mosi3};
        if (nrise3 == 0) t_first3 = $time;
        t_last3 = $time;
        nrise3++;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic wait_rdy(input bit sel, input int lim);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sel ? ready3 : ready0) && n < lim);
        chk(sel ? "rdy3_wait" : "rdy0_wait", 16'(sel ? ready3 : ready0), 16'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        transmit0 = 1'b0; command0 = '0;
        transmit3 = 1'b0; command3 = '0;
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_ready", 16'(ready0), 16'd1);
        chk("rst_cs", 16'(cs0), 16'd1);
        chk("rst_sclk", 16'(sclk0), 16'd0);
        chk("rst_valid", 16'(valid0), 16'd0);
        chk("rst_tx", 16'(tx0), 16'h00);
        chk("rst_mosi", 16'(mosi0), 16'd0);
        chk("rst_sclk3", 16'(sclk3), 16'd1);
        rst = 1'b1;
        @(negedge clk);

        // single transaction, transmit held two clocks
        ncs0 = 0; vq0.delete(); resp_q0.push_back(8'hA5);
        command0 = 3'd3; transmit0 = 1'b1;
        @(negedge clk);
        chk("a_ready_low", 16'(ready0), 16'd0);
        chk("a_setup_cs", 16'(cs0), 16'd0);
        chk("a_setup_sclk", 16'(sclk0), 16'd0);
        @(negedge clk);
        transmit0 = 1'b0;
        wait_rdy(1'b0, 200);
        chk("a_mosi", cap0, 16'h0300);
        chk("a_nrise", 16'(nrise0), 16'd16);
        chk("a_ncs", 16'(ncs0), 16'd1);
        chk("a_nvalid", 16'(vq0.size()), 16'd1);
        chk("a_tx", 16'(tx0), 16'h00A5);
        chk("a_idle_sclk", 16'(sclk0), 16'd0);
        chk("a_idle_mosi", 16'(mosi0), 16'd0);

        // transmit while busy is dropped
        ncs0 = 0; vq0.delete(); resp_q0.push_back(8'h5A);
        command0 = 3'd6; transmit0 = 1'b1;
        @(negedge clk);
        transmit0 = 1'b0;
        repeat (20) @(negedge clk);
        command0 = 3'd5; transmit0 = 1'b1;
        @(negedge clk);
        transmit0 = 1'b0;
        wait_rdy(1'b0, 200);
        repeat (5) @(negedge clk);
        chk("b_mosi", cap0, 16'h0600);
        chk("b_ncs", 16'(ncs0), 16'd1);
        chk("b_nvalid", 16'(vq0.size()), 16'd1);
        chk("b_tx", 16'(tx0), 16'h005A);
        chk("b_cs_idle", 16'(cs0), 16'd1);

        // back-to-back with transmit held high
        ncs0 = 0; vq0.delete(); mq0.delete();
        resp_q0.push_back(8'h3C); resp_q0.push_back(8'hC3);
        command0 = 3'd7; transmit0 = 1'b1;
        @(negedge clk);
        command0 = 3'd1;
        wait_rdy(1'b0, 200);
        @(negedge clk);
        transmit0 = 1'b0;
        chk("c_accept2", 16'(ready0), 16'd0);
        wait_rdy(1'b0, 200);
        chk("c_ncs", 16'(ncs0), 16'd2);
        chk("c_gap", 16'(gap0), 16'd3);
        chk("c_nvalid", 16'(vq0.size()), 16'd2);
        chk("c_nmosi", 16'(mq0.size()), 16'd2);
        if (vq0.size() == 2) begin
            chk("c_tx1", 16'(vq0[0]), 16'h003C);
            chk("c_tx2", 16'(vq0[1]), 16'h00C3);
        end
        if (mq0.size() == 2) begin
            chk("c_mosi1", mq0[0], 16'h0700);
            chk("c_mosi2", mq0[1], 16'h0100);
        end

        // reset during the command byte aborts the transfer
        vq0.delete(); resp_q0.push_back(8'h99);
        command0 = 3'd4; transmit0 = 1'b1;
        @(negedge clk);
        transmit0 = 1'b0;
        repeat (10) @(negedge clk);
        chk("d_in_cmd", 16'(cs0), 16'd0);
        rst = 1'b0;
        #1;
        chk("d_cs", 16'(cs0), 16'd1);
        chk("d_sclk", 16'(sclk0), 16'd0);
        chk("d_ready", 16'(ready0), 16'd1);
        chk("d_mosi", 16'(mosi0), 16'd0);
        repeat (3) @(negedge clk);
        chk("d_nvalid", 16'(vq0.size()), 16'd0);
        chk("d_tx", 16'(tx0), 16'h0000);
        rst = 1'b1;
        @(negedge clk);
        resp_q0.push_back(8'h4E);
        command0 = 3'd2; transmit0 = 1'b1;
        @(negedge clk);
        transmit0 = 1'b0;
        wait_rdy(1'b0, 200);
        chk("d_tx2", 16'(tx0), 16'h004E);
        chk("d_mosi2", cap0, 16'h0200);
        chk("d_nvalid2", 16'(vq0.size()), 16'd1);

        // mode 3, 4 clks per half bit
        vq3.delete(); resp_q3.push_back(8'h81);
        command3 = 3'd2; transmit3 = 1'b1;
        @(negedge clk);
        transmit3 = 1'b0;
        chk("e_setup_cs", 16'(cs3), 16'd0);
        chk("e_setup_sclk", 16'(sclk3), 16'd1);
        wait_rdy(1'b1, 400);
        chk("e_tx", 16'(tx3), 16'h0081);
        chk("e_mosi", cap3, 16'h0200);
        chk("e_nrise", 16'(nrise3), 16'd16);
        chk("e_span", 16'(t_last3 - t_first3), 16'd1200);
        chk("e_nvalid", 16'(vq3.size()), 16'd1);
        chk("e_idle_sclk", 16'(sclk3), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
